mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single external memory port between the core's instruction-fetch side and data-access side, so the processor can run from one unified memory. The block sits between `top`'s IAD/IDT/ACKI_n and DAD/DDT/MREQ/WRITE/SIZE/ACKD_n buses and the memory model. Data accesses get priority, and a bounded-streak rule guarantees fetch progress. A timeout converts a hung memory access into an error response.

## Interface
- `MAX_DSTREAK`, 4: consecutive data grants allowed while a fetch is pending
- `TIMEOUT`, 255: cycles in ISSUE without memory ack before abort (1..65535)
- `ERR_DATA`, 32'hDEADBEEF: read data returned on timeout
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-low reset
- `IREQ` in 1: fetch request, held until ACKI_n low
- `IAD` in 32: fetch address
- `IDT` out 32: fetch data, registered
- `ACKI_n` out 1: fetch acknowledge, active-low, one-cycle pulse
- `MREQ` in 1: data request, held until ACKD_n low
- `WRITE` in 1: 1 = store
- `SIZE` in 2: 00 word, 01 half, others byte
- `DAD` in 32: data address
- `DDT_W` in 32: store data
- `DDT_R` out 32: load data, registered
- `ACKD_n` out 1: data acknowledge, active-low, one-cycle pulse
- `M_REQ` out 1: memory request
- `M_WRITE` out 1: memory write
- `M_SIZE` out 2: memory size
- `M_AD` out 32: memory address
- `M_WDT` out 32: memory write data
- `M_RDT` in 32: memory read data
- `M_ACK_n` in 1: memory acknowledge, active-low
- `ERR` out 1: timeout flag, high together with the aborted access's ACKx_n pulse

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- **IDLE:** sample `IREQ`/`MREQ`.
  - Neither request: stay in IDLE.
  - Otherwise: latch winner, address, size, write and write data into `M_*` registers, then go to ISSUE.
- **Arbitration (IDLE only):**
  - Only one request: it wins.
  - Both requests: data wins unless `streak == MAX_DSTREAK`, in which case fetch wins.
  - Fetch grants always use `M_WRITE`=0 and `M_SIZE`=00.
- **Streak counter:**
  - Increments on each data grant made while `IREQ`=1.
  - Clears on a fetch grant, and on any IDLE cycle with `IREQ`=0.
  - Saturates at `MAX_DSTREAK`.
- **ISSUE:**
  - `M_REQ`=1; `M_*` held constant; the timeout counter increments each cycle.
  - `M_ACK_n`=0 at a clock edge: capture `M_RDT` into `IDT` or `DDT_R` according to the winner, then go to RESP.
  - Counter reaches `TIMEOUT` with no ack: load `ERR_DATA` into the winner's data register, set the error flag, then go to RESP.
- **RESP:**
  - `M_REQ`=0.
  - Exactly one of `ACKI_n`/`ACKD_n` is 0; `ERR`=1 if the access was aborted.
  - Next state is IDLE unconditionally. A request still asserted during RESP is not re-arbitrated until the following IDLE cycle.
- **Read data:** passed through unchanged. Half and byte reads arrive zero-extended from memory.
- **Stores:** `DDT_R` is left unchanged.
- **Protocol violation:** a requester dropping its request mid-access does not cancel the access; the ack is still issued.
- **Reset mid-access (`rst`=0 at any time):** immediately forces IDLE and reset values. In-flight data is discarded.
- **Reset values:**
  - `M_REQ`, `M_WRITE`, `ERR` = 0
  - `M_SIZE` = 00
  - `M_AD`, `M_WDT`, `IDT`, `DDT_R` = 0
  - `ACKI_n`, `ACKD_n` = 1
  - FSM = IDLE; streak = 0; timeout counter = 0

## Timing
- Every output is registered; there is no combinational path from inputs to outputs.
- Cycle 0: request sampled in IDLE.
- Cycle 1: `M_REQ` high.
- Memory with latency L asserts `M_ACK_n` low in the L-th ISSUE cycle.
- The ACKx_n pulse appears in the cycle after that edge.
- Total request-to-ack latency is L+1 cycles. With L=1 the throughput is one access per 3 cycles.
- A timeout ack appears `TIMEOUT`+1 cycles after `M_REQ` rises.
- The timeout counter clears on entry to ISSUE and is 16 bits wide.

## Structure
- Shared package `mem_bus_pkg` holds:
  - SIZE encodings (`SZ_WORD`, `SZ_HALF`, `SZ_BYTE`)
  - FSM state enum
  - default `ERR_DATA`
  - the `STDOUT_ADDR`/`EXIT_ADDR` constants, for reuse by bus decoders
- One sub-module, `mem_arb_pick`: combinational winner selection from `IREQ`, `MREQ` and streak, plus the streak next-value.

## Test plan
- Fetch only, L=1, `IAD`=0x100, `M_RDT`=0x00400093 → `M_REQ` high in cycle 1; `ACKI_n`=0 in cycle 2 with `IDT`=0x00400093; `ACKD_n` stays 1.
- `IREQ` and `MREQ` (store 0x12345678 to 0x40, `SIZE`=00) asserted together and held → data served first, fetch second; `M_WDT`=0x12345678 during the store's ISSUE.
- `MREQ` held continuously with `IREQ`=1, `MAX_DSTREAK`=4 → exactly 4 data grants, then 1 fetch grant, repeating.
- Memory never acks, `TIMEOUT`=8, data load → `ACKD_n`=0 and `ERR`=1 in the same cycle, 9 cycles after `M_REQ` rises; `DDT_R`=0xDEADBEEF; next access proceeds normally.
- `rst` pulled low during ISSUE of an L=3 access → `M_REQ`=0 and `ACKD_n`=1 immediately. After release, a new request completes with correct data and no stale ack.
- Byte store to 0xF0000000, `DDT_W`=0x41 → `M_SIZE`=10, `M_AD`=0xF0000000, `M_WDT`=0x41; `ACKD_n` pulses once.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the unified memory bus.
package mem_bus_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Memory-mapped I/O addresses, shared with the bus decoders.
  localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hF000_0004;

  // One latched memory access as presented on the M_* port.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] ad;
    logic [31:0] wdt;
  } mem_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data, plus the data-streak next value.
module mem_arb_pick #(
  parameter int MAX_DSTREAK = 4,
  parameter int SW          = 3
) (
  input  logic          ireq,
  input  logic          mreq,
  input  logic [SW-1:0] streak,
  output logic          gnt,
  output logic          gnt_d,
  output logic [SW-1:0] streak_nxt
);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);

  // Data wins ties until the streak is exhausted; the streak only grows while a fetch waits.
  always_comb begin
    gnt        = ireq | mreq;
    gnt_d      = mreq & (~ireq | (streak != MAX_S));
    streak_nxt = '0;
    if (ireq && gnt_d)
      streak_nxt = (streak == MAX_S) ? streak : streak + SW'(1);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          MAX_DSTREAK = 4,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IREQ,
  input  logic [31:0] IAD,
  output logic [31:0] IDT,
  output logic        ACKI_n,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  input  logic [31:0] DDT_W,
  output logic [31:0] DDT_R,
  output logic        ACKD_n,
  output logic        M_REQ,
  output logic        M_WRITE,
  output logic [1:0]  M_SIZE,
  output logic [31:0] M_AD,
  output logic [31:0] M_WDT,
  input  logic [31:0] M_RDT,
  input  logic        M_ACK_n,
  output logic        ERR
);
  localparam int          SW  = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  arb_state_e  state_q, state_d;
  mem_req_t    mr_q, mr_d;
  logic        win_d_q, win_d_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [SW-1:0] streak_q, streak_d, streak_nxt;
  logic [31:0] idt_q, idt_d, ddt_q, ddt_d, rdata;
  logic        m_req_q, m_req_d, acki_n_q, acki_n_d, ackd_n_q, ackd_n_d, err_q, err_d;
  logic        gnt, gnt_d;

  mem_arb_pick #(.MAX_DSTREAK(MAX_DSTREAK), .SW(SW)) u_pick (
    .ireq      (IREQ),
    .mreq      (MREQ),
    .streak    (streak_q),
    .gnt       (gnt),
    .gnt_d     (gnt_d),
    .streak_nxt(streak_nxt)
  );

  // Next state: arbitrate in IDLE, wait for ack or timeout in ISSUE, pulse ack in RESP.
  always_comb begin
    state_d  = state_q;
    mr_d     = mr_q;
    win_d_d  = win_d_q;
    tcnt_d   = tcnt_q;
    streak_d = streak_q;
    idt_d    = idt_q;
    ddt_d    = ddt_q;
    m_req_d  = 1'b0;
    acki_n_d = 1'b1;
    ackd_n_d = 1'b1;
    err_d    = 1'b0;
    rdata    = M_ACK_n ? ERR_DATA : M_RDT;
    unique case (state_q)
      ST_IDLE: begin
        streak_d = streak_nxt;
        if (gnt) begin
          win_d_d = gnt_d;
          if (gnt_d) begin
            mr_d.write = WRITE;
            mr_d.size  = SIZE;
            mr_d.ad    = DAD;
            mr_d.wdt   = DDT_W;
          end else begin
            mr_d.write = 1'b0;
            mr_d.size  = SZ_WORD;
            mr_d.ad    = IAD;
            mr_d.wdt   = '0;
          end
          tcnt_d  = '0;
          m_req_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_req_d = 1'b1;
        // An ack on the same edge as the timeout takes precedence.
        if (!M_ACK_n || tcnt_q == TMO) begin
          m_req_d = 1'b0;
          err_d   = M_ACK_n;
          state_d = ST_RESP;
          if (win_d_q) begin
            ackd_n_d = 1'b0;
            // Stores never disturb the load-data register, aborted or not.
            if (!mr_q.write) ddt_d = rdata;
          end else begin
            acki_n_d = 1'b0;
            idt_d    = rdata;
          end
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mr_q     <= '0;
      win_d_q  <= 1'b0;
      tcnt_q   <= '0;
      streak_q <= '0;
      idt_q    <= '0;
      ddt_q    <= '0;
      m_req_q  <= 1'b0;
      acki_n_q <= 1'b1;
      ackd_n_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mr_q     <= mr_d;
      win_d_q  <= win_d_d;
      tcnt_q   <= tcnt_d;
      streak_q <= streak_d;
      idt_q    <= idt_d;
      ddt_q    <= ddt_d;
      m_req_q  <= m_req_d;
      acki_n_q <= acki_n_d;
      ackd_n_q <= ackd_n_d;
      err_q    <= err_d;
    end
  end

  assign M_REQ   = m_req_q;
  assign M_WRITE = mr_q.write;
  assign M_SIZE  = mr_q.size;
  assign M_AD    = mr_q.ad;
  assign M_WDT   = mr_q.wdt;
  assign IDT     = idt_q;
  assign DDT_R   = ddt_q;
  assign ACKI_n  = acki_n_q;
  assign ACKD_n  = ackd_n_q;
  assign ERR     = err_q;
endmodule
